esram_access_arbiter: RTL
=========================

// Module: esram_access_arbiter
// PURPOSE
//  Shares the single eSRAM write port and the single eSRAM read port between NUM_WR writers and NUM_RD readers.
//  Uses per-port round-robin arbitration and a registered issue stage.
//  Tracks in-flight reads with a fixed-latency tag pipeline, so each read response is returned to the reader that issued it.
//  Sits between the packet-buffer clients and esram_wrapper; all signals are in the clk_esram domain.
// PARAMETERS
//  NUM_RD      4    read requesters (2..8)
//  NUM_WR      2    write requesters (1..4)
//  AWIDTH      17   eSRAM word address width
//  DWIDTH      520  eSRAM word data width
//  RD_LATENCY  12   esram rden -> rd_valid cycles (12 hard eSRAM, 2 USE_BRAM)
// PORTS
//  clk_esram       in   1               clock
//  rst             in   1               synchronous active-high reset
//  esram_pll_lock  in   1               eSRAM ready; 0 = hold all grants
//  rd_req_valid    in   NUM_RD          read request per reader
//  rd_req_addr     in   NUM_RD*AWIDTH   read address, reader i at [i*AWIDTH+:AWIDTH]
//  rd_req_ready    out  NUM_RD          one-hot grant; request accepted when valid&ready
//  rd_resp_valid   out  NUM_RD          one-hot: read data for reader i
//  rd_resp_data    out  DWIDTH          shared read data (= esram rddata)
//  wr_req_valid    in   NUM_WR          write request per writer
//  wr_req_addr     in   NUM_WR*AWIDTH   write address
//  wr_req_data     in   NUM_WR*DWIDTH   write data
//  wr_req_ready    out  NUM_WR          one-hot grant
//  esram_rden      out  1               to esram_wrapper rden
//  esram_rdaddress out  AWIDTH          to esram_wrapper rdaddress
//  esram_wren      out  1               to esram_wrapper wren
//  esram_wraddress out  AWIDTH          to esram_wrapper wraddress
//  esram_wrdata    out  DWIDTH          to esram_wrapper wrdata
//  esram_rd_valid  in   1               from esram_wrapper rd_valid
//  esram_rddata    in   DWIDTH          from esram_wrapper rddata
//  err_orphan      out  1               sticky: rd_valid arrived with no matching tag
// BEHAVIOUR
//  Reset:
//   - all registered outputs 0; rd/wr RR pointers 0; tag pipe cleared; err_orphan 0.
//   - ready/resp outputs 0 while rst=1.
//  Arbitration (each port, independent, combinational per cycle):
//   - search starts at the pointer and grants the first valid requester.
//   - after a grant, pointer <= granted+1 (mod N); with no grant the pointer holds.
//   - ready is asserted only to the granted requester, and only if it is valid.
//  Issue: accepted request is registered; esram_* asserted the cycle after acceptance, for exactly 1 cycle.
//   - esram_rdaddress, esram_wraddress, esram_wrdata hold their last value when idle.
//  Lock gating: esram_pll_lock=0 -> every ready=0, esram_rden=esram_wren=0; pointers hold.
//  Hazard: if the read winner's addr == write winner's addr in the same cycle:
//   - the read grant is suppressed (all rd_req_ready=0) and the write proceeds.
//   - the read pointer holds, so the same reader wins next cycle and reads the new data.
//  Tag pipe: RD_LATENCY-deep shift of {valid, reader_id}, loaded from the issue stage when esram_rden=1.
//   - rd_resp_valid[i] = esram_rd_valid & tag_out.valid & (tag_out.id==i); combinational.
//   - rd_resp_data = esram_rddata passthrough.
//   - accept at cycle T -> rden at T+1 -> rd_resp_valid at T+1+RD_LATENCY.
//   - responses return in issue order; throughput is 1 read + 1 write per cycle.
//  Orphan: esram_rd_valid=1 with tag_out.valid=0 -> err_orphan<=1 (sticky until rst).
//   - tag_out.valid=1 with esram_rd_valid=0 also sets err_orphan.
//  Reset mid-flight: in-flight reads are dropped; no rd_resp_valid for them.
//   - err_orphan is masked for RD_LATENCY+1 cycles after rst deasserts (drain window, down-counter).
//  No requester backpressure on responses: readers must always sink rd_resp_valid.
// TESTING
//  1) RD_LATENCY=12, reader0 addr 0x00010 accepted cyc 5:
//     esram_rden=1 cyc 6 only; rd_resp_valid=4'b0001 cyc 18 with model data.
//  2) all 4 readers valid 8 cycles:
//     grants 0,1,2,3,0,1,2,3, one per cycle; responses in the same order; no gaps.
//  3) writer1 and reader2 both target 0x1ABCD in cyc 10:
//     wren cyc 11, reader2 accepted cyc 11, rd_resp data == written data.
//  4) esram_pll_lock=0 for 20 cycles with all requests valid:
//     no ready, no rden/wren; lock=1 -> first grant to reader at the held pointer.
//  5) inject esram_rd_valid with tag pipe empty: err_orphan=1 next cycle and stays 1.
//  6) rst for 1 cycle with 5 reads outstanding; wrapper still returns 5 rd_valid:
//     no rd_resp_valid pulses; err_orphan stays 0.

Source files
------------

// File: rtl/esram_access_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// esram_access_arbiter: round-robin sharing of the eSRAM read/write ports,
// with a fixed-latency tag pipe that routes each read response to its reader.
// Rev 1.0
// ----------------------------------------------------------------------------
module esram_access_arbiter #(
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int AWIDTH     = 17,
  parameter int DWIDTH     = 520,
  parameter int RD_LATENCY = 12
) (
  input  logic                     clk_esram,
  input  logic                     rst,
  input  logic                     esram_pll_lock,
  input  logic [NUM_RD-1:0]        rd_req_valid,
  input  logic [NUM_RD*AWIDTH-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]        rd_req_ready,
  output logic [NUM_RD-1:0]        rd_resp_valid,
  output logic [DWIDTH-1:0]        rd_resp_data,
  input  logic [NUM_WR-1:0]        wr_req_valid,
  input  logic [NUM_WR*AWIDTH-1:0] wr_req_addr,
  input  logic [NUM_WR*DWIDTH-1:0] wr_req_data,
  output logic [NUM_WR-1:0]        wr_req_ready,
  output logic                     esram_rden,
  output logic [AWIDTH-1:0]        esram_rdaddress,
  output logic                     esram_wren,
  output logic [AWIDTH-1:0]        esram_wraddress,
  output logic [DWIDTH-1:0]        esram_wrdata,
  input  logic                     esram_rd_valid,
  input  logic [DWIDTH-1:0]        esram_rddata,
  output logic                     err_orphan
);

  localparam int RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int MCW = $clog2(RD_LATENCY + 2);

  logic [AWIDTH-1:0] rd_addr_a [NUM_RD];
  logic [AWIDTH-1:0] wr_addr_a [NUM_WR];
  logic [DWIDTH-1:0] wr_data_a [NUM_WR];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_unpack
    assign rd_addr_a[i] = rd_req_addr[i*AWIDTH +: AWIDTH];
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
    assign wr_addr_a[i] = wr_req_addr[i*AWIDTH +: AWIDTH];
    assign wr_data_a[i] = wr_req_data[i*DWIDTH +: DWIDTH];
  end

  logic [RPW-1:0] rd_ptr_q, rd_ptr_d, rd_win, rd_idx;
  logic [WPW-1:0] wr_ptr_q, wr_ptr_d, wr_win, wr_idx;
  logic           rd_found, wr_found;
  logic           hazard, rd_grant, wr_grant;
  logic [AWIDTH-1:0] rd_win_addr, wr_win_addr;
  logic [DWIDTH-1:0] wr_win_data;

  always_comb begin
    rd_found = 1'b0;
    rd_win   = '0;
    rd_idx   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_idx = RPW'((int'(rd_ptr_q) + k) % NUM_RD);
      if (!rd_found && rd_req_valid[rd_idx]) begin
        rd_found = 1'b1;
        rd_win   = rd_idx;
      end
    end
  end

  always_comb begin
    wr_found = 1'b0;
    wr_win   = '0;
    wr_idx   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_idx = WPW'((int'(wr_ptr_q) + k) % NUM_WR);
      if (!wr_found && wr_req_valid[wr_idx]) begin
        wr_found = 1'b1;
        wr_win   = wr_idx;
      end
    end
  end

  assign rd_win_addr = rd_addr_a[rd_win];
  assign wr_win_addr = wr_addr_a[wr_win];
  assign wr_win_data = wr_data_a[wr_win];

  // Same-address read loses to the write; its pointer holds so it retries next cycle.
  assign hazard   = rd_found && wr_found && (rd_win_addr == wr_win_addr);
  assign rd_grant = !rst && esram_pll_lock && rd_found && !hazard;
  assign wr_grant = !rst && esram_pll_lock && wr_found;

  always_comb begin
    rd_req_ready = '0;
    wr_req_ready = '0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    if (rd_grant) begin
      rd_req_ready[rd_win] = 1'b1;
      rd_ptr_d = (int'(rd_win) == NUM_RD - 1) ? '0 : rd_win + RPW'(1);
    end
    if (wr_grant) begin
      wr_req_ready[wr_win] = 1'b1;
      wr_ptr_d = (int'(wr_win) == NUM_WR - 1) ? '0 : wr_win + WPW'(1);
    end
  end

  logic              rden_q, wren_q;
  logic [AWIDTH-1:0] rdaddr_q, wraddr_q;
  logic [DWIDTH-1:0] wrdata_q;
  logic [RPW-1:0]    rd_id_q;

  always_ff @(posedge clk_esram) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      rdaddr_q <= '0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      rd_id_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rden_q   <= rd_grant;
      wren_q   <= wr_grant;
      if (rd_grant) begin
        rdaddr_q <= rd_win_addr;
        rd_id_q  <= rd_win;
      end
      if (wr_grant) begin
        wraddr_q <= wr_win_addr;
        wrdata_q <= wr_win_data;
      end
    end
  end

  assign esram_rden      = rden_q;
  assign esram_rdaddress = rdaddr_q;
  assign esram_wren      = wren_q;
  assign esram_wraddress = wraddr_q;
  assign esram_wrdata    = wrdata_q;

  logic           tag_vld_q [RD_LATENCY];
  logic [RPW-1:0] tag_id_q  [RD_LATENCY];
  logic           tag_out_vld;
  logic [RPW-1:0] tag_out_id;

  always_ff @(posedge clk_esram) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= rden_q;
      tag_id_q[0]  <= rd_id_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign tag_out_vld = tag_vld_q[RD_LATENCY-1];
  assign tag_out_id  = tag_id_q[RD_LATENCY-1];

  always_comb begin
    rd_resp_valid = '0;
    if (!rst && esram_rd_valid && tag_out_vld) rd_resp_valid[tag_out_id] = 1'b1;
  end

  assign rd_resp_data = esram_rddata;

  // Reads issued before a reset still come back from the wrapper; ignore them
  // until the pipe has had time to drain.
  logic [MCW-1:0] mask_q;
  logic           err_q;

  always_ff @(posedge clk_esram) begin
    if (rst) begin
      mask_q <= MCW'(RD_LATENCY + 1);
      err_q  <= 1'b0;
    end else if (mask_q != '0) begin
      mask_q <= mask_q - MCW'(1);
    end else if (esram_rd_valid != tag_out_vld) begin
      err_q  <= 1'b1;
    end
  end

  assign err_orphan = err_q;

endmodule
`default_nettype wire
